// File: rtl/cmd_decoder.sv
// cmd_decoder: byte-stream command decoder.
//
// Pulls 5-byte packets {SYNC, CMD, DHI, DLO, CSUM} from an rx FIFO. It
// executes a register write (CMD[7]=0) or a register read (CMD[7]=1) and
// pushes the response bytes to a tx FIFO. A good write answers ACK. A good
// read answers ACK, RDATA[15:8], RDATA[7:0]. A bad checksum answers NAK.
// If the gap between two bytes of one packet grows too long, the partial
// packet is dropped silently and err_pulse is raised.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rx_rdata/rx_rempty    head byte and empty flag of the rx FIFO
//   rx_rinc               pop the head rx byte this cycle
//   tx_wdata/tx_winc      response byte and write strobe to the tx FIFO
//   tx_wfull              tx FIFO full
//   reg_addr/reg_wdata    register address / write data (held between packets)
//   reg_we/reg_re         one-cycle register write / read strobes
//   reg_rdata             read data, valid the cycle after reg_re
//   busy                  high whenever a packet or response is in flight
//   err_pulse             one-cycle flag on checksum error or timeout
//
// Handshake: the FIFOs use a valid/ready pair. On rx, valid is !rx_rempty
// and ready is the receive state, so a byte moves on a clk edge only when
// rx_rinc=1 (= !rx_rempty && receive state). On tx, valid is the response
// state and ready is !tx_wfull, so a byte moves only when tx_winc=1
// (= response state && !tx_wfull). Otherwise both sides hold their data.

module cmd_decoder #(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_rdata,
  input  logic        rx_rempty,
  output logic        rx_rinc,
  output logic [7:0]  tx_wdata,
  input  logic        tx_wfull,
  output logic        tx_winc,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        err_pulse
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ACK      = 8'h06;
  localparam logic [7:0]    NAK      = 8'h15;

  localparam logic [3:0] S_HUNT   = 4'd0;
  localparam logic [3:0] S_CMD    = 4'd1;
  localparam logic [3:0] S_DHI    = 4'd2;
  localparam logic [3:0] S_DLO    = 4'd3;
  localparam logic [3:0] S_CSUM   = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_RDWAIT = 4'd6;
  localparam logic [3:0] S_RESP0  = 4'd7;
  localparam logic [3:0] S_RESP1  = 4'd8;
  localparam logic [3:0] S_RESP2  = 4'd9;

  logic [3:0]    state;
  logic [CW-1:0] gap_cnt;
  logic [7:0]    cmd_q;
  logic [7:0]    dhi_q;
  logic [7:0]    dlo_q;
  logic [15:0]   rdata_q;
  logic          nak_q;

  logic rx_state;
  logic resp_state;
  logic pkt_state;
  logic csum_ok;

  always_comb begin
    rx_state   = (state inside {S_HUNT, S_CMD, S_DHI, S_DLO, S_CSUM});
    pkt_state  = (state inside {S_CMD, S_DHI, S_DLO, S_CSUM});
    resp_state = (state inside {S_RESP0, S_RESP1, S_RESP2});
    csum_ok    = (rx_rdata == (cmd_q ^ dhi_q ^ dlo_q));
  end

  // Gating the outputs with rst_n keeps them quiet while reset is held,
  // including before the first clock edge has set up the state.
  assign rx_rinc = rst_n & rx_state & ~rx_rempty;
  assign tx_winc = rst_n & resp_state & ~tx_wfull;
  assign busy    = rst_n & (state != S_HUNT);
  assign reg_we  = rst_n & (state == S_EXEC) & ~cmd_q[7];
  assign reg_re  = rst_n & (state == S_EXEC) & cmd_q[7];

  always_comb begin
    tx_wdata = 8'h00;
    case (state)
      S_RESP0: tx_wdata = nak_q ? NAK : ACK;
      S_RESP1: tx_wdata = rdata_q[15:8];
      S_RESP2: tx_wdata = rdata_q[7:0];
      default: tx_wdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      gap_cnt   <= '0;
      cmd_q     <= 8'h00;
      dhi_q     <= 8'h00;
      dlo_q     <= 8'h00;
      rdata_q   <= 16'h0000;
      nak_q     <= 1'b0;
      reg_addr  <= 7'h00;
      reg_wdata <= 16'h0000;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (state == S_HUNT) begin
        gap_cnt <= '0;
        if (!rx_rempty && rx_rdata == SYNC_BYTE) state <= S_CMD;
      end else if (pkt_state) begin
        if (!rx_rempty) begin
          // Every byte here is payload, even one equal to SYNC_BYTE.
          gap_cnt <= '0;
          if (state == S_CMD) begin
            cmd_q <= rx_rdata;
            state <= S_DHI;
          end else if (state == S_DHI) begin
            dhi_q <= rx_rdata;
            state <= S_DLO;
          end else if (state == S_DLO) begin
            dlo_q <= rx_rdata;
            state <= S_CSUM;
          end else if (csum_ok) begin
            // Only a good packet touches the register-side address/data.
            reg_addr  <= cmd_q[6:0];
            reg_wdata <= {dhi_q, dlo_q};
            nak_q     <= 1'b0;
            state     <= S_EXEC;
          end else begin
            nak_q     <= 1'b1;
            err_pulse <= 1'b1;
            state     <= S_RESP0;
          end
        end else if (gap_cnt == GAP_LAST) begin
          gap_cnt   <= '0;
          err_pulse <= 1'b1;
          state     <= S_HUNT;
        end else begin
          gap_cnt <= gap_cnt + CW'(1);
        end
      end else begin
        gap_cnt <= '0;
        case (state)
          S_EXEC:   state <= cmd_q[7] ? S_RDWAIT : S_RESP0;
          S_RDWAIT: begin
            rdata_q <= reg_rdata;
            state   <= S_RESP0;
          end
          S_RESP0:  if (!tx_wfull) state <= (!nak_q && cmd_q[7]) ? S_RESP1 : S_HUNT;
          S_RESP1:  if (!tx_wfull) state <= S_RESP2;
          S_RESP2:  if (!tx_wfull) state <= S_HUNT;
          default:  state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
